// File: rtl/sprite_renderer_if.sv
// Sprite renderer bus: sprite positions/status in, pixel write port out.
// Latency: none (wires only).
// Backpressure: none; the pixel sink must take one pixel per cycle while plot is high.
interface sprite_renderer_if;
    logic       play;
    logic [7:0] playerX;
    logic [6:0] playerY;
    logic [7:0] enemyX;
    logic [6:0] enemyY;
    logic [2:0] enemy_size;
    logic       player_hit;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       frame_done;

    modport master (
        input  play, playerX, playerY, enemyX, enemyY, enemy_size, player_hit,
        output vga_x, vga_y, vga_colour, plot, busy, frame_done
    );

    modport slave (
        output play, playerX, playerY, enemyX, enemyY, enemy_size, player_hit,
        input  vga_x, vga_y, vga_colour, plot, busy, frame_done
    );
endinterface

// File: rtl/sprite_renderer.sv
// Sprite renderer: per frame tick, erases last frame's player/enemy squares and draws the new ones (SPRITE_RENDERER_HIT_FLASH_EN adds hit flashing).
// Latency: first pixel in the cycle after the tick; pixel outputs are combinational from state, one pixel per cycle.
// Backpressure: none; the pixel sink must accept every plot strobe.
module sprite_renderer #(
    parameter int         FRAME_DIV     = 833332,
    parameter int         PLAYER_SIZE   = 3,
    parameter logic [2:0] BG_COLOUR     = 3'b000,
    parameter logic [2:0] PLAYER_COLOUR = 3'b111,
    parameter logic [2:0] ENEMY_COLOUR  = 3'b100,
    parameter logic [2:0] HIT_COLOUR    = 3'b110
) (
    input  logic               clk,
    input  logic               resetn,
    sprite_renderer_if.master  bus
);
    localparam int         CW    = (FRAME_DIV < 1) ? 1 : $clog2(FRAME_DIV + 1);
    localparam logic [7:0] PSIZE = 8'(PLAYER_SIZE);

    // Encoding order matters: a pass state's value is the index of the pass after it.
    typedef enum logic [2:0] {
        IDLE = 3'd0, ERASE_P = 3'd1, ERASE_E = 3'd2, DRAW_P = 3'd3, DRAW_E = 3'd4, DONE = 3'd5
    } state_e;

    // First non-empty pass at or after pass index from_i (0 = ERASE_P .. 3 = DRAW_E).
    function automatic state_e pick(input logic [2:0] from_i, input logic [3:0] act);
        state_e r;
        r = DONE;
        if (act[3] && from_i <= 3'd3) r = DRAW_E;
        if (act[2] && from_i <= 3'd2) r = DRAW_P;
        if (act[1] && from_i <= 3'd1) r = ERASE_E;
        if (act[0] && from_i == 3'd0) r = ERASE_P;
        return r;
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    ox_q, ox_d, oy_q, oy_d;
    logic [7:0]    new_px_q, new_px_d, new_ex_q, new_ex_d;
    logic [6:0]    new_py_q, new_py_d, new_ey_q, new_ey_d;
    logic [2:0]    new_es_q, new_es_d;
    logic [7:0]    prev_px_q, prev_px_d, prev_ex_q, prev_ex_d;
    logic [6:0]    prev_py_q, prev_py_d, prev_ey_q, prev_ey_d;
    logic [2:0]    prev_es_q, prev_es_d;
    logic          prev_valid_q, prev_valid_d;
`ifdef SPRITE_RENDERER_HIT_FLASH_EN
    logic          new_hit_q, new_hit_d;
    logic          parity_q, parity_d;
`endif

    logic [7:0] cur_size, base_x;
    logic [6:0] base_y;
    logic [8:0] px, py;
    logic       in_pass;
    logic [2:0] es_src;
    logic [3:0] act;

    always_comb begin
        cur_size = PSIZE;
        base_x   = new_px_q;
        base_y   = new_py_q;
        in_pass  = 1'b1;
        case (state_q)
            ERASE_P: begin base_x = prev_px_q; base_y = prev_py_q; end
            ERASE_E: begin base_x = prev_ex_q; base_y = prev_ey_q; cur_size = {5'd0, prev_es_q}; end
            DRAW_P:  begin base_x = new_px_q;  base_y = new_py_q;  end
            DRAW_E:  begin base_x = new_ex_q;  base_y = new_ey_q;  cur_size = {5'd0, new_es_q}; end
            default: in_pass = 1'b0;
        endcase
        // 9-bit sums so an offset past the screen edge never wraps back on-screen.
        px = {1'b0, base_x} + {1'b0, ox_q};
        py = {2'b00, base_y} + {1'b0, oy_q};

        bus.plot       = in_pass && (px < 9'd160) && (py < 9'd120);
        bus.vga_x      = in_pass ? px[7:0] : 8'd0;
        bus.vga_y      = in_pass ? py[6:0] : 7'd0;
        bus.vga_colour = BG_COLOUR;
        if (state_q == DRAW_E) bus.vga_colour = ENEMY_COLOUR;
        if (state_q == DRAW_P) begin
`ifdef SPRITE_RENDERER_HIT_FLASH_EN
            bus.vga_colour = (new_hit_q && parity_q) ? HIT_COLOUR : PLAYER_COLOUR;
`else
            bus.vga_colour = PLAYER_COLOUR;
`endif
        end
        bus.busy       = (state_q != IDLE);
        bus.frame_done = (state_q == DONE);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        new_px_d     = new_px_q;
        new_py_d     = new_py_q;
        new_ex_d     = new_ex_q;
        new_ey_d     = new_ey_q;
        new_es_d     = new_es_q;
        prev_px_d    = prev_px_q;
        prev_py_d    = prev_py_q;
        prev_ex_d    = prev_ex_q;
        prev_ey_d    = prev_ey_q;
        prev_es_d    = prev_es_q;
        prev_valid_d = prev_valid_q;
`ifdef SPRITE_RENDERER_HIT_FLASH_EN
        new_hit_d    = new_hit_q;
        parity_d     = parity_q;
`endif
        // On the tick cycle the enemy size has not been latched yet, so look at the live input.
        es_src = (state_q == IDLE) ? bus.enemy_size : new_es_q;
        act    = {es_src != 3'd0, PSIZE != 8'd0,
                  prev_valid_q && (prev_es_q != 3'd0), prev_valid_q && (PSIZE != 8'd0)};

        case (state_q)
            IDLE: begin
                if (bus.play) begin
                    if (cnt_q == CW'(FRAME_DIV)) begin
                        cnt_d    = '0;
                        new_px_d = bus.playerX;
                        new_py_d = bus.playerY;
                        new_ex_d = bus.enemyX;
                        new_ey_d = bus.enemyY;
                        new_es_d = bus.enemy_size;
`ifdef SPRITE_RENDERER_HIT_FLASH_EN
                        new_hit_d = bus.player_hit;
`endif
                        state_d  = pick(3'd0, act);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                prev_px_d    = new_px_q;
                prev_py_d    = new_py_q;
                prev_ex_d    = new_ex_q;
                prev_ey_d    = new_ey_q;
                prev_es_d    = new_es_q;
                prev_valid_d = 1'b1;
`ifdef SPRITE_RENDERER_HIT_FLASH_EN
                parity_d     = ~parity_q;
`endif
                state_d      = IDLE;
            end
            default: begin
                if (ox_q == cur_size - 8'd1) begin
                    ox_d = 8'd0;
                    if (oy_q == cur_size - 8'd1) begin
                        oy_d    = 8'd0;
                        state_d = pick(state_q, act);
                    end else begin
                        oy_d = oy_q + 8'd1;
                    end
                end else begin
                    ox_d = ox_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            new_px_q     <= '0;
            new_py_q     <= '0;
            new_ex_q     <= '0;
            new_ey_q     <= '0;
            new_es_q     <= '0;
            prev_px_q    <= '0;
            prev_py_q    <= '0;
            prev_ex_q    <= '0;
            prev_ey_q    <= '0;
            prev_es_q    <= '0;
            prev_valid_q <= 1'b0;
`ifdef SPRITE_RENDERER_HIT_FLASH_EN
            new_hit_q    <= 1'b0;
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            new_px_q     <= new_px_d;
            new_py_q     <= new_py_d;
            new_ex_q     <= new_ex_d;
            new_ey_q     <= new_ey_d;
            new_es_q     <= new_es_d;
            prev_px_q    <= prev_px_d;
            prev_py_q    <= prev_py_d;
            prev_ex_q    <= prev_ex_d;
            prev_ey_q    <= prev_ey_d;
            prev_es_q    <= prev_es_d;
            prev_valid_q <= prev_valid_d;
`ifdef SPRITE_RENDERER_HIT_FLASH_EN
            new_hit_q    <= new_hit_d;
            parity_q     <= parity_d;
`endif
        end
    end
endmodule

// File: doc/sprite_renderer.md
SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 Parameter FRAME_DIV, default 833332, sets clk cycles between frame ticks minus one (60 Hz at 50 MHz).
REQ-002 Parameter PLAYER_SIZE, default 3, sets the player square edge in pixels.
REQ-003 Parameters BG_COLOUR 3'b000, PLAYER_COLOUR 3'b111, ENEMY_COLOUR 3'b100 and HIT_COLOUR 3'b110 set the pixel colours.
REQ-004 clk  in  1  sole clock; all state SHALL update on posedge clk.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 play  in  1  frame ticks are counted only while high.
REQ-007 playerX  in  8, playerY  in  7  player top-left pixel.
REQ-008 enemyX  in  8, enemyY  in  7  enemy top-left pixel.
REQ-009 enemy_size  in  3  enemy square edge in pixels.
REQ-010 player_hit  in  1  collision flag.
REQ-011 vga_x  out  8, vga_y  out  7, vga_colour  out  3  pixel write address and data.
REQ-012 plot  out  1  pixel write strobe, valid in the same cycle as vga_x, vga_y and vga_colour.
REQ-013 busy  out  1  high in every non-IDLE state; frame_done  out  1  single-cycle pulse.

Function
REQ-014 Frame counter SHALL increment while play=1 and state=IDLE; at count==FRAME_DIV it SHALL clear and assert an internal tick; it SHALL hold while play=0.
REQ-015 Tick cycle SHALL latch playerX/Y, enemyX/Y, enemy_size and player_hit as "new" and go to ERASE_P.
REQ-016 FSM: IDLE -> ERASE_P -> ERASE_E -> DRAW_P -> DRAW_E -> DONE -> IDLE.
REQ-017 ERASE_P/ERASE_E SHALL write BG_COLOUR over the previous frame's latched player/enemy squares; DRAW_P SHALL draw the new player square; DRAW_E SHALL draw the new enemy square in ENEMY_COLOUR.
REQ-018 Each square SHALL emit one pixel per cycle, row-major with x offset as the inner loop, starting at offset (0,0).
REQ-019 A player pass SHALL last PLAYER_SIZE^2 cycles; an enemy pass SHALL last size^2 cycles; a size of 0 SHALL skip that pass in zero cycles.
REQ-020 Pixels with x>=160 or y>=120 SHALL take their cycle with plot=0; coordinate arithmetic SHALL be 9-bit so offsets never wrap.
REQ-021 ERASE_P and ERASE_E SHALL be skipped (zero cycles) while prev_valid=0.
REQ-022 DONE SHALL last one cycle, pulse frame_done, copy "new" to "previous" and set prev_valid=1.
REQ-023 Input changes during a frame SHALL NOT affect that frame; play falling mid-frame SHALL NOT abort the frame.
REQ-024 plot SHALL be 0 in IDLE and DONE.

Reset
REQ-025 resetn=0 SHALL immediately force state=IDLE, frame counter=0, prev_valid=0, plot=0, busy=0, frame_done=0, vga_x=0, vga_y=0 and vga_colour=BG_COLOUR, including mid-frame.
REQ-026 The first frame after reset SHALL draw only, with no erase passes.

Configuration
REQ-027 With macro SPRITE_RENDERER_HIT_FLASH_EN defined, a frame-parity bit SHALL toggle every DONE, and with latched player_hit=1 the player SHALL be drawn in HIT_COLOUR on odd frames and PLAYER_COLOUR on even frames.
REQ-028 Without SPRITE_RENDERER_HIT_FLASH_EN, the player SHALL always be drawn in PLAYER_COLOUR, player_hit SHALL be ignored and no parity register SHALL exist.

Verification
REQ-029 FRAME_DIV=4, play=1, reset release, player (80,100), enemy (10,20) size 2 -> tick after 5 cycles; 9 white pixels (80..82,100..102), then 4 pixels of colour 100 at (10..11,20..21); frame_done on cycle 14 after the tick.
REQ-030 Second frame with player moved to (81,100) -> first 9 plots are BG at (80..82,100..102), then 4 BG enemy pixels, then 13 draw pixels; busy high for 27 cycles.
REQ-031 Enemy at (159,119) size 3 -> only the pixel at (159,119) has plot=1; the enemy pass still takes 9 cycles.
REQ-032 resetn pulsed low during DRAW_P -> plot=0 and busy=0 in the same cycle; the next frame has no erase passes.
REQ-033 play=0 for 100 cycles -> no tick occurs and the counter holds its value; counting resumes when play returns high.
REQ-034 With the HIT_FLASH_EN macro and player_hit=1 held -> the player colour alternates 110/111 across consecutive frames.
